// File: rtl/alu_pkg.sv
// Shared opcode map, flag bundle and the width-generic compute function for the pipelined ALU.
// Operands arrive zero-extended to 32 bits; the active width is passed in so one function serves every WIDTH.
package alu_pkg;

    localparam int MAXW = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDS = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULL = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_ACC  = 4'd12;
    localparam logic [3:0] OP_CLR  = 4'd13;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic err;
    } alu_flags_t;

    typedef struct packed {
        logic [MAXW-1:0] res;
        alu_flags_t      flags;
    } alu_res_t;

    function automatic alu_res_t alu_compute(
        input int unsigned w,
        input int unsigned shw,
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] acc
    );
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] amt;
        logic [31:0] res;
        logic [31:0] sra_ext;
        logic [63:0] wide;
        alu_res_t    r;

        mask    = 32'((33'd1 << w) - 33'd1);
        msb     = 32'd1 << (w - 1);
        amt     = b & 32'((33'd1 << shw) - 33'd1);
        res     = '0;
        wide    = '0;
        sra_ext = ((a & msb) != 0) ? (a | ~mask) : a;
        r       = '0;

        case (op)
            OP_ADD: begin
                wide      = 64'(a) + 64'(b);
                res       = 32'(wide) & mask;
                r.flags.c = (wide >> w) != 0;
                r.flags.v = |(~(a ^ b) & (a ^ res) & msb);
            end
            OP_SUB: begin
                res       = (a - b) & mask;
                r.flags.c = a < b;
                r.flags.v = |((a ^ b) & (a ^ res) & msb);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            // Flipping the sign bit turns a signed compare into an unsigned one.
            OP_SLT: res = {31'b0, (a ^ msb) < (b ^ msb)};
            OP_ADDS: begin
                wide      = 64'(a) + 64'(b);
                res       = 32'(wide) & mask;
                r.flags.c = (wide >> w) != 0;
                r.flags.v = |(~(a ^ b) & (a ^ res) & msb);
                if (r.flags.v) begin
                    res = ((a & msb) != 0) ? msb : (msb - 32'd1);
                end
            end
            OP_SHL: res = (a << amt) & mask;
            OP_SHR: res = a >> amt;
            OP_SRA: res = 32'($signed(sra_ext) >>> amt) & mask;
            OP_MULL: begin
                wide = 64'(a) * 64'(b);
                res  = 32'(wide) & mask;
            end
            OP_MULH: begin
                wide = 64'(a) * 64'(b);
                res  = 32'(wide >> w) & mask;
            end
            OP_ACC: begin
                wide      = 64'(acc) + 64'(a);
                res       = 32'(wide) & mask;
                r.flags.c = (wide >> w) != 0;
                r.flags.v = |(~(acc ^ a) & (acc ^ res) & msb);
            end
            OP_CLR: res = '0;
            default: r.flags.err = 1'b1;
        endcase

        r.res     = res;
        r.flags.z = (res == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe: valid/ready on the input side and on the result side.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic [OPW-1:0]   instruction;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, inputA, inputB, instruction, out_ready,
        input  in_ready, out_valid, alu_out, flag_z, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, inputA, inputB, instruction, out_ready,
        output in_ready, out_valid, alu_out, flag_z, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_core.sv
// Combinational compute unit: narrows the width-generic package function to this instance's WIDTH.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);
    alu_res_t r;

    always_comb begin
        r      = alu_compute(WIDTH, SHW, op, 32'(a), 32'(b), 32'(acc));
        result = WIDTH'(r.res);
        flags  = r.flags;
    end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 registers the operation, stage 2 holds the computed result.
// rst_n asserts asynchronously; its release is expected to be synchronous to clk.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [OPW-1:0]   s1_op_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] out_reg;
    alu_flags_t       flags_reg;
    logic [WIDTH-1:0] acc_reg;

    logic             s2_accept;
    logic [3:0]       s1_op4;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    // Ready ripples back combinationally, so a full pipe still moves every cycle the consumer pops.
    assign s2_accept    = !s2_valid_reg || bus.out_ready;
    assign bus.in_ready = !s1_valid_reg || s2_accept;
    assign s1_op4       = 4'(s1_op_reg);

    alu_core #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_core (
        .op    (s1_op4),
        .a     (s1_a_reg),
        .b     (s1_b_reg),
        .acc   (acc_reg),
        .result(core_result),
        .flags (core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
            s2_valid_reg <= 1'b0;
            out_reg      <= '0;
            flags_reg    <= '0;
            acc_reg      <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_reg  <= bus.inputA;
                    s1_b_reg  <= bus.inputB;
                    s1_op_reg <= bus.instruction;
                end
            end
            if (s2_accept) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_reg   <= core_result;
                    flags_reg <= core_flags;
                    // Updating here means the next op in stage 1 already sees the new value.
                    if (s1_op4 == OP_ACC || s1_op4 == OP_CLR) begin
                        acc_reg <= core_result;
                    end
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.alu_out   = out_reg;
    assign bus.flag_z    = flags_reg.z;
    assign bus.flag_c    = flags_reg.c;
    assign bus.flag_v    = flags_reg.v;
    assign bus.err       = flags_reg.err;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH 8 and 16: directed corner cases, latency sweep, stalls, reset and random traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  f;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8))  bus8 ();
    alu_pipe_if #(.WIDTH(16)) bus16 ();

    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    exp_t        q8[$];
    exp_t        q16[$];
    longint      acc_m[2];
    bit          hold_p[2];
    logic [35:0] hold_v[2];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    bit          fired8 = 0;
    bit          dir_valid = 0;
    exp_t        dir_exp;

    function automatic exp_t model(input int w, input int op, input longint a, input longint b,
                                   inout longint acc);
        longint m, h, sa, sb, sc, t, r, d;
        bit c, v, er;
        exp_t e;
        m  = longint'(1) << w;
        h  = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        sc = (acc >= h) ? acc - m : acc;
        d  = longint'(1) << (b % w);
        r = 0; c = 0; v = 0; er = 0;
        case (op)
            0: begin r = (a + b) % m; c = (a + b) >= m; v = (sa + sb >= h) || (sa + sb < -h); end
            1: begin r = (a - b + m) % m; c = a < b; v = (sa - sb >= h) || (sa - sb < -h); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 1 : 0;
            6: begin
                t = sa + sb; c = (a + b) >= m; v = (t >= h) || (t < -h);
                if (t >= h) t = h - 1; else if (t < -h) t = -h;
                r = (t + m) % m;
            end
            7: r = (a * d) % m;
            8: r = a / d;
            9: begin t = sa / d; if (sa < 0 && t * d != sa) t = t - 1; r = (t + m) % m; end
            10: r = (a * b) % m;
            11: r = (a * b) / m;
            12: begin
                r = (acc + a) % m; c = (acc + a) >= m; v = (sc + sa >= h) || (sc + sa < -h);
                acc = r;
            end
            13: begin r = 0; acc = 0; end
            default: er = 1;
        endcase
        e.res = 32'(r);
        e.f   = {r == 0, c, v, er};
        e.cyc = 0;
        return e;
    endfunction

    task automatic score(input int s, input bit ov, input bit ordy, input logic [31:0] res,
                         input logic [3:0] f);
        exp_t e;
        bit   have;
        if (hold_p[s]) begin
            n_assert++;
            assert (ov === 1'b1 && {res, f} === hold_v[s]) else begin
                n_fail++;
                $error("FAIL hold_w%0d got valid=%b %h/%b expected valid=1 %h", s, ov, res, f, hold_v[s]);
            end
        end
        hold_p[s] = ov && !ordy;
        hold_v[s] = {res, f};
        if (ov && ordy) begin
            have = (s == 0) ? (q8.size() > 0) : (q16.size() > 0);
            n_assert++;
            assert (have) else begin
                n_fail++;
                $error("FAIL spurious_w%0d got result %h expected no out_valid", s, res);
            end
            if (have) begin
                e = (s == 0) ? q8.pop_front() : q16.pop_front();
                n_assert++;
                assert ({res, f} === {e.res, e.f}) else begin
                    n_fail++;
                    $error("FAIL result_w%0d got %h zcve=%b expected %h zcve=%b", s, res, f, e.res, e.f);
                end
                if (lat_chk) begin
                    n_assert++;
                    assert (cyc - e.cyc == 2) else begin
                        n_fail++;
                        $error("FAIL latency_w%0d got %0d expected 2", s, cyc - e.cyc);
                    end
                end
            end
        end
    endtask

    // One clock: score outputs at the falling edge, then log accepted operations after the rising edge.
    task automatic tick();
        bit          f8, f16;
        logic [3:0]  op8, op16;
        logic [31:0] a8, b8, a16, b16;
        int          pres;
        exp_t        e;
        @(negedge clk);
        pres = cyc;
        f8   = bus8.in_valid && bus8.in_ready;
        f16  = bus16.in_valid && bus16.in_ready;
        op8  = bus8.instruction;  a8  = 32'(bus8.inputA);  b8  = 32'(bus8.inputB);
        op16 = bus16.instruction; a16 = 32'(bus16.inputA); b16 = 32'(bus16.inputB);
        score(0, bus8.out_valid, bus8.out_ready, 32'(bus8.alu_out),
              {bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.err});
        score(1, bus16.out_valid, bus16.out_ready, 32'(bus16.alu_out),
              {bus16.flag_z, bus16.flag_c, bus16.flag_v, bus16.err});
        @(posedge clk);
        #1;
        cyc++;
        fired8 = f8;
        if (f8) begin
            e = model(8, int'(op8), longint'(a8), longint'(b8), acc_m[0]);
            if (dir_valid) begin
                e = dir_exp;
                dir_valid = 0;
            end
            e.cyc = pres;
            q8.push_back(e);
        end
        if (f16) begin
            e = model(16, int'(op16), longint'(a16), longint'(b16), acc_m[1]);
            e.cyc = pres;
            q16.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bus8.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.instruction = op;
        bus8.inputA      = a;
        bus8.inputB      = b;
        bus8.in_valid    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fired8) break;
        end
        n_assert++;
        assert (fired8) else begin
            n_fail++;
            $error("FAIL accept_timeout got in_ready=%b expected 1", bus8.in_ready);
        end
    endtask

    task automatic send8d(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] res, input logic [3:0] f);
        dir_exp.res = 32'(res);
        dir_exp.f   = f;
        dir_exp.cyc = 0;
        dir_valid   = 1;
        send8(op, a, b);
    endtask

    initial begin
        int          acc_cnt;
        logic [7:0]  bv;
        acc_m[0] = 0; acc_m[1] = 0;
        hold_p[0] = 0; hold_p[1] = 0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;  bus8.instruction = '0;  bus8.inputA = '0;  bus8.inputB = '0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.instruction = '0; bus16.inputA = '0; bus16.inputB = '0;

        #1 rst_n = 1'b0;
        #2;
        n_assert++;
        assert (bus8.out_valid === 1'b0 && bus16.out_valid === 1'b0) else begin
            n_fail++; $error("FAIL reset_out_valid got %b/%b expected 0/0", bus8.out_valid, bus16.out_valid);
        end
        n_assert++;
        assert (bus8.in_ready === 1'b1 && bus16.in_ready === 1'b1) else begin
            n_fail++; $error("FAIL reset_in_ready got %b/%b expected 1/1", bus8.in_ready, bus16.in_ready);
        end
        n_assert++;
        assert ({bus8.alu_out, bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.err} === 12'h000) else begin
            n_fail++; $error("FAIL reset_outputs got %h/%b%b%b%b expected 00/0000", bus8.alu_out,
                             bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.err);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed corners; flags written as {z,c,v,err}.
        send8d(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100);
        send8d(OP_ADDS, 8'h80, 8'hFF, 8'h80, 4'b0110);
        send8d(OP_ADDS, 8'h7F, 8'h01, 8'h7F, 4'b0010);
        send8d(OP_SRA, 8'h90, 8'h0B, 8'hF2, 4'b0000);
        send8d(OP_CLR, 8'h33, 8'h00, 8'h00, 4'b1000);
        send8d(OP_ACC, 8'd5, 8'h00, 8'd5, 4'b0000);
        send8d(OP_ACC, 8'd7, 8'h00, 8'd12, 4'b0000);
        send8d(OP_ACC, 8'd250, 8'h00, 8'd6, 4'b0100);
        send8d(4'd15, 8'h03, 8'h04, 8'h00, 4'b1001);
        send8d(OP_ACC, 8'd0, 8'h00, 8'd6, 4'b0000);
        idle(4);

        // Back-pressure: two ops fill the pipe, the third waits for the consumer.
        bus8.out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            bus8.in_valid = (acc_cnt < 3); bus8.instruction = OP_ADD;
            bus8.inputA = 8'(acc_cnt * 10 + 1); bus8.inputB = 8'(acc_cnt + 2);
            tick();
            if (fired8) acc_cnt++;
        end
        n_assert++;
        assert (acc_cnt == 2 && bus8.in_ready === 1'b0 && bus8.out_valid === 1'b1) else begin
            n_fail++; $error("FAIL stall_fill got accepted=%0d in_ready=%b out_valid=%b expected 2/0/1",
                             acc_cnt, bus8.in_ready, bus8.out_valid);
        end
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 10 && acc_cnt < 3; k++) begin
            bus8.in_valid = 1'b1; bus8.instruction = OP_ADD;
            bus8.inputA = 8'(acc_cnt * 10 + 1); bus8.inputB = 8'(acc_cnt + 2);
            tick();
            if (fired8) acc_cnt++;
        end
        idle(4);
        n_assert++;
        assert (acc_cnt == 3 && q8.size() == 0) else begin
            n_fail++; $error("FAIL stall_drain got accepted=%0d pending=%0d expected 3/0", acc_cnt, q8.size());
        end

        // Full-rate sweep of every legal op with latency checked on each result.
        lat_chk = 1;
        for (int op = 0; op < 14; op++) begin
            for (int a = 0; a < 256; a++) begin
                for (int j = 0; j < 6; j++) begin
                    case (j)
                        0: bv = 8'h00;
                        1: bv = 8'h01;
                        2: bv = 8'h7F;
                        3: bv = 8'h80;
                        4: bv = 8'hFF;
                        default: bv = 8'($urandom);
                    endcase
                    send8(4'(op), 8'(a), bv);
                end
            end
        end
        idle(3);
        lat_chk = 0;
        n_assert++;
        assert (q8.size() == 0) else begin
            n_fail++; $error("FAIL sweep_drain got pending=%0d expected 0", q8.size());
        end

        // Reset in the middle of traffic.
        for (int i = 0; i < 6; i++) send8(4'($urandom_range(0, 13)), 8'($urandom), 8'($urandom));
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        assert (bus8.out_valid === 1'b0 && bus8.in_ready === 1'b1) else begin
            n_fail++; $error("FAIL midreset got out_valid=%b in_ready=%b expected 0/1", bus8.out_valid, bus8.in_ready);
        end
        q8.delete(); q16.delete();
        acc_m[0] = 0; acc_m[1] = 0;
        hold_p[0] = 0; hold_p[1] = 0;
        dir_valid = 0;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        n_assert++;
        assert (bus8.out_valid === 1'b0) else begin
            n_fail++; $error("FAIL post_reset_stale got out_valid=%b expected 0", bus8.out_valid);
        end
        send8d(OP_ACC, 8'd9, 8'h00, 8'd9, 4'b0000);
        idle(3);

        // Random traffic with random back-pressure on both widths.
        for (int i = 0; i < 4000; i++) begin
            bus8.in_valid     = ($urandom_range(0, 3) != 0);
            bus8.instruction  = 4'($urandom_range(0, 15));
            bus8.inputA       = 8'($urandom);
            bus8.inputB       = 8'($urandom);
            bus8.out_ready    = ($urandom_range(0, 2) != 0);
            bus16.in_valid    = ($urandom_range(0, 3) != 0);
            bus16.instruction = 4'($urandom_range(0, 15));
            bus16.inputA      = 16'($urandom);
            bus16.inputB      = 16'($urandom);
            bus16.out_ready   = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus8.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        idle(5);
        n_assert++;
        assert (q8.size() == 0 && q16.size() == 0) else begin
            n_fail++; $error("FAIL random_drain got pending=%0d/%0d expected 0/0", q8.size(), q16.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
